// File: rtl/stopwatch_ctrl_if.sv
// Control/status bundle between the stopwatch controller, its button panel and
// the BCD counter datapath.
interface stopwatch_ctrl_if;
    logic        start_stop_p;
    logic        clear_p;
    logic        lap_p;
    logic        alarm_en;
    logic [15:0] alarm_bcd;
    logic [15:0] cnt_bcd;
    logic        cnt_en;
    logic        cnt_clr;
    logic [15:0] disp_bcd;
    logic        buzzer;
    logic        led_blink_en;
    logic [1:0]  state;

    // The panel/datapath side
    modport master (
        output start_stop_p, clear_p, lap_p, alarm_en, alarm_bcd, cnt_bcd,
        input  cnt_en, cnt_clr, disp_bcd, buzzer, led_blink_en, state
    );

    // The controller side
    modport slave (
        input  start_stop_p, clear_p, lap_p, alarm_en, alarm_bcd, cnt_bcd,
        output cnt_en, cnt_clr, disp_bcd, buzzer, led_blink_en, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/pause/clear FSM with lap hold and a one-shot
// mm:ss alarm that sounds for ALARM_SECS clk1hz cycles.
module stopwatch_ctrl #(
    parameter int ALARM_SECS = 5
) (
    input  logic             clk1hz,
    input  logic             rstn,
    stopwatch_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    localparam logic [3:0] ALARM_LOAD = 4'(ALARM_SECS - 1);

    state_t      state_r;
    state_t      state_nxt;
    logic        hold_r;
    logic        hold_nxt;
    logic [15:0] lap_r;
    logic [15:0] lap_nxt;
    logic [3:0]  timer_r;
    logic [3:0]  timer_nxt;
    logic        armed_r;
    logic        armed_nxt;
    logic        clr_r;
    logic        setpoint_ok;
    logic        match;

    // A zero or malformed setpoint simply never matches
    assign setpoint_ok = (bus.alarm_bcd[3:0]   <= 4'd9) &&
                         (bus.alarm_bcd[7:4]   <= 4'd5) &&
                         (bus.alarm_bcd[11:8]  <= 4'd9) &&
                         (bus.alarm_bcd[15:12] <= 4'd9) &&
                         (bus.alarm_bcd != 16'h0000);

    assign match = (state_r == RUN) && bus.alarm_en && armed_r &&
                   (bus.cnt_bcd == bus.alarm_bcd) && setpoint_ok;

    always_ff @(posedge clk1hz or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
            hold_r  <= 1'b0;
            lap_r   <= 16'h0000;
            timer_r <= 4'd0;
            armed_r <= 1'b1;
            clr_r   <= 1'b0;
        end else begin
            state_r <= state_nxt;
            hold_r  <= hold_nxt;
            lap_r   <= lap_nxt;
            timer_r <= timer_nxt;
            armed_r <= armed_nxt;
            clr_r   <= bus.clear_p;
        end
    end

    always_comb begin
        state_nxt = state_r;
        timer_nxt = timer_r;
        hold_nxt  = hold_r;
        lap_nxt   = lap_r;
        armed_nxt = armed_r;

        if (bus.clear_p) begin
            state_nxt = IDLE;
            timer_nxt = 4'd0;
        end else if (bus.start_stop_p) begin
            timer_nxt = 4'd0;
            case (state_r)
                IDLE, PAUSE: state_nxt = RUN;
                default:     state_nxt = PAUSE;
            endcase
        end else if (match) begin
            state_nxt = ALARM;
            timer_nxt = ALARM_LOAD;
        end else if (state_r == ALARM) begin
            if (timer_r == 4'd0) begin
                state_nxt = RUN;
            end else begin
                timer_nxt = timer_r - 4'd1;
            end
        end

        // Re-arm once the count moves off the setpoint so each pass fires once
        if (match && !bus.clear_p && !bus.start_stop_p) begin
            armed_nxt = 1'b0;
        end else if ((bus.cnt_bcd != bus.alarm_bcd) || !bus.alarm_en) begin
            armed_nxt = 1'b1;
        end

        if (bus.clear_p) begin
            hold_nxt = 1'b0;
        end else if (bus.lap_p && (state_r != IDLE)) begin
            if (hold_r) begin
                hold_nxt = 1'b0;
            end else if ((state_r == RUN) || (state_r == ALARM)) begin
                lap_nxt  = bus.cnt_bcd;
                hold_nxt = 1'b1;
            end
        end
    end

    assign bus.state        = state_r;
    assign bus.cnt_en       = (state_r == RUN) || (state_r == ALARM);
    assign bus.cnt_clr      = clr_r;
    assign bus.buzzer       = (state_r == ALARM);
    assign bus.led_blink_en = (state_r == ALARM);
    assign bus.disp_bcd     = hold_r ? lap_r : bus.cnt_bcd;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: the bench plays the BCD counter
// datapath and predicts every output with a seconds-based behavioural model.
module tb_stopwatch_ctrl;
    localparam int ALARM_SECS = 5;

    logic clk1hz = 1'b0;
    logic rstn;
    stopwatch_ctrl_if bus();

    stopwatch_ctrl #(.ALARM_SECS(ALARM_SECS)) dut (
        .clk1hz (clk1hz),
        .rstn   (rstn),
        .bus    (bus)
    );

    always #5 clk1hz = ~clk1hz;

    int n_checks = 0;
    int n_errors = 0;

    // Model: mode 0 idle, 1 running, 2 paused, 3 sounding
    int          m_st;
    int          m_left;
    int          m_secs;
    bit          m_hold;
    bit          m_armed;
    bit          m_clr;
    logic [15:0] m_lap;
    logic [15:0] cur_cnt;
    logic [15:0] force_val;
    bit          freeze;
    bit          use_force;

    function automatic logic [15:0] to_bcd(input int s);
        int mm = (s % 3600) / 60;
        int ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic bit bcd_ok(input logic [15:0] a);
        for (int k = 0; k < 4; k++)
            if (((a >> (4 * k)) & 16'hF) > 9) return 1'b0;
        if (((a >> 4) & 16'hF) > 5) return 1'b0;
        return a != 16'h0000;
    endfunction

    function automatic logic [21:0] exp_vec();
        bit running = (m_st == 1) || (m_st == 3);
        return {2'(m_st), running, m_clr, m_st == 3, m_st == 3,
                m_hold ? m_lap : cur_cnt};
    endfunction

    function automatic logic [21:0] obs_vec();
        return {bus.state, bus.cnt_en, bus.cnt_clr, bus.buzzer,
                bus.led_blink_en, bus.disp_bcd};
    endfunction

    task automatic model_reset();
        m_st = 0; m_left = 0; m_hold = 0; m_armed = 1; m_clr = 0; m_lap = 16'h0000;
    endtask

    task automatic drive_cnt();
        cur_cnt = use_force ? force_val : to_bcd(m_secs);
        bus.cnt_bcd = cur_cnt;
    endtask

    // One clk1hz cycle: apply pulses, advance model and datapath, settle
    task automatic tick(input bit ss, input bit clr, input bit lp);
        bit match;
        int nst;
        bit running;
        bus.start_stop_p = ss;
        bus.clear_p      = clr;
        bus.lap_p        = lp;
        running = (m_st == 1) || (m_st == 3);
        match = (m_st == 1) && bus.alarm_en && m_armed &&
                (cur_cnt == bus.alarm_bcd) && bcd_ok(bus.alarm_bcd);
        nst = m_st;
        if (clr) nst = 0;
        else if (ss) nst = running ? 2 : 1;
        else if (match) begin nst = 3; m_left = ALARM_SECS; end
        else if (m_st == 3) begin
            m_left--;
            if (m_left == 0) nst = 1;
        end
        if (match && !clr && !ss) m_armed = 0;
        else if ((cur_cnt != bus.alarm_bcd) || !bus.alarm_en) m_armed = 1;
        if (clr) m_hold = 0;
        else if (lp && m_st != 0) begin
            if (m_hold) m_hold = 0;
            else if (running) begin m_lap = cur_cnt; m_hold = 1; end
        end
        if (m_clr) m_secs = 0;
        else if (running && !freeze) m_secs = (m_secs + 1) % 3600;
        m_clr = clr;
        m_st  = nst;
        @(posedge clk1hz);
        @(negedge clk1hz);
        bus.start_stop_p = 1'b0;
        bus.clear_p      = 1'b0;
        bus.lap_p        = 1'b0;
        drive_cnt();
        #1;
    endtask

    task automatic test_reset();
        tick(1, 0, 0);
        tick(0, 0, 1);
        rstn = 1'b0;
        use_force = 1; force_val = 16'h4321; drive_cnt();
        #1;
        model_reset();
        n_checks++;
        if (bus.state !== 2'd0) begin n_errors++; $display("[TB] FAIL reset_state: got %0d want 0", bus.state); end
        n_checks++;
        if ({bus.cnt_en, bus.cnt_clr, bus.buzzer, bus.led_blink_en} !== 4'b0000) begin
            n_errors++; $display("[TB] FAIL reset_outputs: got %b want 0000",
                                 {bus.cnt_en, bus.cnt_clr, bus.buzzer, bus.led_blink_en});
        end
        n_checks++;
        if (bus.disp_bcd !== 16'h4321) begin n_errors++; $display("[TB] FAIL reset_disp: got %h want 4321", bus.disp_bcd); end
        @(negedge clk1hz);
        rstn = 1'b1;
        use_force = 0; drive_cnt();
        #1;
        tick(0, 0, 0);
        n_checks++;
        if (obs_vec() !== exp_vec()) begin n_errors++; $display("[TB] FAIL reset_idle: got %h want %h", obs_vec(), exp_vec()); end
    endtask

    task automatic test_run_pause();
        logic [1:0] want [3] = '{2'd1, 2'd2, 2'd1};
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 0);
            n_checks++;
            if (bus.state !== want[i] || bus.cnt_en !== (want[i] == 2'd1)) begin
                n_errors++; $display("[TB] FAIL run_pause step %0d: got state %0d en %b want state %0d", i, bus.state, bus.cnt_en, want[i]);
            end
            n_checks++;
            if (obs_vec() !== exp_vec()) begin n_errors++; $display("[TB] FAIL run_pause_model step %0d: got %h want %h", i, obs_vec(), exp_vec()); end
        end
    endtask

    task automatic test_alarm();
        int k = 0;
        int n_buzz = 0;
        tick(0, 1, 0);
        tick(0, 0, 0);
        bus.alarm_en = 1'b1; bus.alarm_bcd = 16'h0010;
        m_secs = 5; drive_cnt();
        tick(1, 0, 0);
        while (cur_cnt != 16'h0010 && k < 20) begin
            tick(0, 0, 0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin n_errors++; $display("[TB] FAIL alarm_approach %0d: got %h want %h", k, obs_vec(), exp_vec()); end
            k++;
        end
        freeze = 1;
        for (int i = 0; i < 12; i++) begin
            tick(0, 0, 0);
            if (bus.buzzer) n_buzz++;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin n_errors++; $display("[TB] FAIL alarm_cycle %0d: got %h want %h", i, obs_vec(), exp_vec()); end
        end
        n_checks++;
        if (n_buzz != ALARM_SECS) begin n_errors++; $display("[TB] FAIL alarm_length: got %0d want %0d", n_buzz, ALARM_SECS); end
        n_checks++;
        if (bus.state !== 2'd1) begin n_errors++; $display("[TB] FAIL alarm_no_refire: got state %0d want 1", bus.state); end
        freeze = 0;
    endtask

    task automatic test_silence_and_clear();
        for (int pass = 0; pass < 2; pass++) begin
            int k = 0;
            bus.alarm_bcd = to_bcd(m_secs + 3);
            while (m_st != 3 && k < 10) begin
                tick(0, 0, 0);
                n_checks++;
                if (obs_vec() !== exp_vec()) begin n_errors++; $display("[TB] FAIL silence_approach %0d: got %h want %h", k, obs_vec(), exp_vec()); end
                k++;
            end
            n_checks++;
            if (bus.state !== 2'd3) begin n_errors++; $display("[TB] FAIL silence_enter: got state %0d want 3", bus.state); end
            if (pass == 0) begin
                tick(1, 0, 0);
                n_checks++;
                if (bus.state !== 2'd2 || bus.buzzer !== 1'b0) begin
                    n_errors++; $display("[TB] FAIL silence_pause: got state %0d buzzer %b want 2/0", bus.state, bus.buzzer);
                end
                tick(1, 0, 0);
            end
        end
        tick(1, 1, 0);
        n_checks++;
        if (bus.state !== 2'd0 || bus.cnt_clr !== 1'b1) begin
            n_errors++; $display("[TB] FAIL clear_priority: got state %0d clr %b want 0/1", bus.state, bus.cnt_clr);
        end
        tick(0, 0, 0);
        n_checks++;
        if (bus.cnt_clr !== 1'b0 || bus.state !== 2'd0) begin
            n_errors++; $display("[TB] FAIL clear_pulse: got state %0d clr %b want 0/0", bus.state, bus.cnt_clr);
        end
    endtask

    task automatic test_lap();
        tick(1, 0, 0);
        m_secs = 83; drive_cnt();
        tick(0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0);
            n_checks++;
            if (bus.disp_bcd !== 16'h0123) begin n_errors++; $display("[TB] FAIL lap_hold %0d: got %h want 0123", i, bus.disp_bcd); end
        end
        tick(0, 0, 1);
        n_checks++;
        if (bus.disp_bcd !== cur_cnt) begin n_errors++; $display("[TB] FAIL lap_release: got %h want %h", bus.disp_bcd, cur_cnt); end
        n_checks++;
        if (obs_vec() !== exp_vec()) begin n_errors++; $display("[TB] FAIL lap_model: got %h want %h", obs_vec(), exp_vec()); end
    endtask

    task automatic test_reset_in_alarm();
        int k = 0;
        bus.alarm_bcd = to_bcd(m_secs + 2);
        while (m_st != 3 && k < 10) begin tick(0, 0, 0); k++; end
        tick(0, 0, 0);
        n_checks++;
        if (bus.buzzer !== 1'b1) begin n_errors++; $display("[TB] FAIL rst_alarm_pre: got buzzer %b want 1", bus.buzzer); end
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({bus.state, bus.buzzer, bus.led_blink_en, bus.cnt_en} !== 5'b00000) begin
            n_errors++; $display("[TB] FAIL rst_alarm_drop: got %b want 00000", {bus.state, bus.buzzer, bus.led_blink_en, bus.cnt_en});
        end
        @(negedge clk1hz);
        rstn = 1'b1;
        #1;
        tick(0, 0, 0);
        n_checks++;
        if (obs_vec() !== exp_vec()) begin n_errors++; $display("[TB] FAIL rst_alarm_idle: got %h want %h", obs_vec(), exp_vec()); end
        tick(1, 0, 0);
        n_checks++;
        if (bus.state !== 2'd1) begin n_errors++; $display("[TB] FAIL rst_alarm_resume: got state %0d want 1", bus.state); end
    endtask

    task automatic test_invalid_setpoint();
        logic [15:0] bad [2] = '{16'h00A0, 16'h0060};
        for (int j = 0; j < 2; j++) begin
            int n_buzz = 0;
            bus.alarm_bcd = bad[j];
            use_force = 1; force_val = bad[j]; drive_cnt();
            for (int i = 0; i < 6; i++) begin
                tick(0, 0, 0);
                if (bus.state == 2'd3) n_buzz++;
                n_checks++;
                if (obs_vec() !== exp_vec()) begin n_errors++; $display("[TB] FAIL invalid_model %0d/%0d: got %h want %h", j, i, obs_vec(), exp_vec()); end
            end
            n_checks++;
            if (n_buzz != 0) begin n_errors++; $display("[TB] FAIL invalid_setpoint %h: got %0d alarm cycles want 0", bad[j], n_buzz); end
        end
        use_force = 0; drive_cnt();
    endtask

    task automatic test_wrap();
        int start [3]        = '{3595, 1, 3597};
        logic [15:0] sp [3]  = '{16'h0000, 16'h0003, 16'h0003};
        int want [3]         = '{0, ALARM_SECS, ALARM_SECS};
        for (int j = 0; j < 3; j++) begin
            int n_buzz = 0;
            bus.alarm_bcd = sp[j];
            m_secs = start[j]; drive_cnt();
            for (int i = 0; i < 12; i++) begin
                tick(0, 0, 0);
                if (bus.buzzer) n_buzz++;
                n_checks++;
                if (obs_vec() !== exp_vec()) begin n_errors++; $display("[TB] FAIL wrap_model %0d/%0d: got %h want %h", j, i, obs_vec(), exp_vec()); end
            end
            n_checks++;
            if (n_buzz != want[j]) begin n_errors++; $display("[TB] FAIL wrap_alarm %0d: got %0d alarm cycles want %0d", j, n_buzz, want[j]); end
        end
    endtask

    task automatic test_random();
        tick(0, 1, 0);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(199) == 0) begin m_secs = int'($urandom_range(3599)); drive_cnt(); end
            if ($urandom_range(49) == 0) bus.alarm_en = ~bus.alarm_en;
            if ($urandom_range(59) == 0) begin
                case ($urandom_range(3))
                    0, 3:    bus.alarm_bcd = to_bcd(m_secs + int'($urandom_range(1, 15)));
                    1:       bus.alarm_bcd = 16'h0000;
                    default: bus.alarm_bcd = 16'($urandom);
                endcase
            end
            tick($urandom_range(11) == 0, $urandom_range(39) == 0, $urandom_range(9) == 0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin n_errors++; $display("[TB] FAIL random cycle %0d: got %h want %h", i, obs_vec(), exp_vec()); end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        bus.start_stop_p = 1'b0; bus.clear_p = 1'b0; bus.lap_p = 1'b0;
        bus.alarm_en = 1'b0; bus.alarm_bcd = 16'h0000;
        freeze = 0; use_force = 0; force_val = 16'h0000; m_secs = 0;
        model_reset();
        drive_cnt();
        repeat (2) @(negedge clk1hz);
        rstn = 1'b1;
        #1;
        test_reset();
        test_run_pause();
        test_alarm();
        test_silence_and_clear();
        test_lap();
        test_reset_in_alarm();
        test_invalid_setpoint();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
